// File: rtl/heap_pkg.sv
// Shared definitions for the heap output-side drain controller.
//   heap_cap()     : number of records a two-sub-heap sorter with nlevels levels can hold
//   FLUSH_KEY      : key value the heap returns for an empty slot
//   drain_st_e     : drain controller FSM encoding
//   is_sentinel()  : true when the low key_width bits of key are all ones
package heap_pkg;

  localparam int unsigned HeapKeyWidth = 7;
  localparam logic [HeapKeyWidth-1:0] FLUSH_KEY = {HeapKeyWidth{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWaitSort,
    StDrain,
    StFinish,
    StDone
  } drain_st_e;

  // Two sub-heaps, each a full binary tree of nlevels-1 levels.
  function automatic int unsigned heap_cap(input int unsigned nlevels);
    return 2 * ((32'd1 << (nlevels - 1)) - 1);
  endfunction

  function automatic logic is_sentinel(input logic [31:0] key, input int unsigned key_width);
    logic [31:0] mask;
    mask = (key_width >= 32) ? '1 : ((32'd1 << key_width) - 32'd1);
    return (key & mask) == mask;
  endfunction

endpackage

// File: rtl/heap_obuf_fifo.sv
// First-word-fall-through output buffer, Width x Depth (Depth a power of two, >= 2).
//   clk, rstn    : clock, asynchronous active-low reset
//   push_i       : write push_data_i (accepted when not full, or when popping the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   pop_data_o   : head entry, forced to zero while empty
//   count_o      : occupancy, empty_o / full_o : status flags
module heap_obuf_fifo #(
  parameter int unsigned Width = 292,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         pop_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AddrW + 1)'(Depth));
  assign count_o = cnt_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/heap_drain_ctrl.sv
// Output-side reader for the two-sub-heap top-K sorter. Starts a heap session, waits for
// sort completion, reads records back with credit-paced flush strobes and streams them out.
//   clk, rstn               : clock, asynchronous active-low reset
//   start, n_items          : begin a session reading up to n_items records (IDLE only)
//   heap_init, heap_flush   : control strobes to the heap
//   heap_sort_end, heap_dout: heap status and record returned FLUSH_LAT cycles after flush
//   m_data, m_valid, m_ready: sorted record stream
//   busy, done, out_count   : status; out_count holds until the next start
module heap_drain_ctrl
  import heap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 292,
  parameter int unsigned KEY_WIDTH  = 7,
  parameter int unsigned NLEVELS    = 6,
  parameter int unsigned FLUSH_LAT  = 0,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [6:0]            n_items,
  output logic                  heap_init,
  output logic                  heap_flush,
  input  logic                  heap_sort_end,
  input  logic [DATA_WIDTH-1:0] heap_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [6:0]            out_count
);

  localparam int unsigned HeapCap = heap_cap(NLEVELS);
  localparam logic [6:0]  CapLim  = 7'(HeapCap);
  localparam int unsigned CntW    = $clog2(OBUF_DEPTH) + 1;

  drain_st_e       state_q, state_d;
  logic [6:0]      limit_q, limit_d;
  logic [6:0]      issued_q, issued_d;
  logic [6:0]      out_count_q, out_count_d;
  logic            stop_q, stop_d;

  logic            start_acc, cap_vld, sentinel, credit_ok;
  logic [7:0]      inflight;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty, fifo_full, fifo_push, fifo_pop;

  // Flush history: stage 0 is heap_flush itself, stages 1..FLUSH_LAT are registered. The
  // last stage marks the cycle heap_dout carries the matching record.
  if (FLUSH_LAT > 0) begin : g_lat
    logic [FLUSH_LAT-1:0] sr_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sr_q <= '0;
      else       sr_q <= (sr_q << 1) | FLUSH_LAT'(heap_flush);
    end
    assign cap_vld  = sr_q[FLUSH_LAT-1];
    assign inflight = 8'($countones(sr_q));
  end else begin : g_nolat
    assign cap_vld  = heap_flush;
    assign inflight = '0;
  end

  assign sentinel  = is_sentinel(32'(heap_dout[KEY_WIDTH-1:0]), KEY_WIDTH);
  // Once the first empty slot is seen, anything still in flight is past the end as well.
  assign fifo_push = cap_vld && !stop_q && !sentinel;
  assign fifo_pop  = m_valid && m_ready;
  assign start_acc = (state_q == StIdle) && start;
  // Every in-flight record must already have a FIFO slot reserved.
  assign credit_ok = (8'(fifo_count) + inflight) < 8'(OBUF_DEPTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StInit;
      StInit:     state_d = (limit_q == '0) ? StDone : StWaitSort;
      StWaitSort: if (heap_sort_end) state_d = StDrain;
      StDrain:    if ((issued_q == limit_q) || stop_q) state_d = StFinish;
      StFinish:   if ((inflight == '0) && fifo_empty) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    heap_init  = (state_q == StInit);
    done       = (state_q == StDone);
    busy       = (state_q != StIdle);
    heap_flush = (state_q == StDrain) && (issued_q < limit_q) && !stop_q && credit_ok;
  end

  always_comb begin
    limit_d     = limit_q;
    issued_d    = issued_q;
    stop_d      = stop_q;
    out_count_d = out_count_q;
    if (start_acc) begin
      limit_d     = (n_items > CapLim) ? CapLim : n_items;
      issued_d    = '0;
      stop_d      = 1'b0;
      out_count_d = '0;
    end else begin
      if (heap_flush)           issued_d    = issued_q + 7'd1;
      if (cap_vld && sentinel)  stop_d      = 1'b1;
      if (fifo_pop)             out_count_d = out_count_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      limit_q     <= '0;
      issued_q    <= '0;
      stop_q      <= 1'b0;
      out_count_q <= '0;
    end else begin
      limit_q     <= limit_d;
      issued_q    <= issued_d;
      stop_q      <= stop_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_count = out_count_q;
  assign m_valid   = !fifo_empty;

  heap_obuf_fifo #(
    .Width (DATA_WIDTH),
    .Depth (OBUF_DEPTH)
  ) u_obuf (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (fifo_push),
    .push_data_i (heap_dout),
    .pop_i       (fifo_pop),
    .pop_data_o  (m_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_heap_drain_ctrl.sv
// Directed bench for heap_drain_ctrl: one instance with FLUSH_LAT=0 and one with FLUSH_LAT=2,
// each fed by a small behavioural heap model; records are checked through scoreboard queues.
module tb_heap_drain_ctrl;

  localparam int DW = 292;
  localparam int KW = 7;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  // ---------------- DUT 0 (FLUSH_LAT = 0) ----------------
  logic          start0, init0, flush0, send0, mv0, mr0, busy0, done0;
  logic [6:0]    n0, oc0;
  logic [DW-1:0] dout0, md0;
  logic [DW-1:0] mem0 [64];
  logic [5:0]    ptr0;
  int            sdly0, scnt0;
  int            fl0, pp0, in0, dn0;
  logic [DW-1:0] q0 [$];

  heap_drain_ctrl #(
    .DATA_WIDTH (DW), .KEY_WIDTH (KW), .NLEVELS (6), .FLUSH_LAT (0), .OBUF_DEPTH (4)
  ) u_dut0 (
    .clk (clk), .rstn (rstn), .start (start0), .n_items (n0),
    .heap_init (init0), .heap_flush (flush0), .heap_sort_end (send0), .heap_dout (dout0),
    .m_data (md0), .m_valid (mv0), .m_ready (mr0),
    .busy (busy0), .done (done0), .out_count (oc0)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr0 <= '0; scnt0 <= 0; send0 <= 1'b0;
    end else if (init0) begin
      ptr0 <= '0; scnt0 <= sdly0; send0 <= (sdly0 == 0);
    end else begin
      if (flush0) ptr0 <= ptr0 + 6'd1;
      if (scnt0 != 0) begin scnt0 <= scnt0 - 1; send0 <= (scnt0 == 1); end
    end
  end
  assign dout0 = mem0[ptr0];

  // ---------------- DUT 1 (FLUSH_LAT = 2) ----------------
  logic          start1, init1, flush1, send1, mv1, mr1, busy1, done1;
  logic [6:0]    n1, oc1;
  logic [DW-1:0] dout1, md1, st1a, st1b;
  logic [DW-1:0] mem1 [64];
  logic [5:0]    ptr1;
  int            scnt1;
  int            fl1, pp1, in1, dn1;
  logic [DW-1:0] q1 [$];

  heap_drain_ctrl #(
    .DATA_WIDTH (DW), .KEY_WIDTH (KW), .NLEVELS (6), .FLUSH_LAT (2), .OBUF_DEPTH (4)
  ) u_dut1 (
    .clk (clk), .rstn (rstn), .start (start1), .n_items (n1),
    .heap_init (init1), .heap_flush (flush1), .heap_sort_end (send1), .heap_dout (dout1),
    .m_data (md1), .m_valid (mv1), .m_ready (mr1),
    .busy (busy1), .done (done1), .out_count (oc1)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr1 <= '0; scnt1 <= 0; send1 <= 1'b0; st1a <= '0; st1b <= '0;
    end else begin
      st1a <= flush1 ? mem1[ptr1] : '0;
      st1b <= st1a;
      if (init1) begin
        ptr1 <= '0; scnt1 <= 3; send1 <= 1'b0;
      end else begin
        if (flush1) ptr1 <= ptr1 + 6'd1;
        if (scnt1 != 0) begin scnt1 <= scnt1 - 1; send1 <= (scnt1 == 1); end
      end
    end
  end
  assign dout1 = st1b;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (flush0) fl0++;
      if (init0)  in0++;
      if (done0)  dn0++;
      if (mv0 && mr0) begin
        pp0++;
        if (q0.size() == 0) chk("dut0_extra_record", 32'(q0.size()), 1);
        else                chk("dut0_record", md0, q0.pop_front());
      end
      if (flush0) chk("dut0_credit", (fl0 - pp0) <= 4, 1);
      if (done0)  chk("dut0_drained_at_done", 32'(q0.size()), 0);
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (flush1) fl1++;
      if (init1)  in1++;
      if (done1)  dn1++;
      if (mv1 && mr1) begin
        pp1++;
        if (q1.size() == 0) chk("dut1_extra_record", 32'(q1.size()), 1);
        else                chk("dut1_record", md1, q1.pop_front());
      end
      if (flush1) chk("dut1_credit", (fl1 - pp1) <= 4, 1);
      if (done1)  chk("dut1_drained_at_done", 32'(q1.size()), 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [6:0] ktab [64];

  task automatic load_heap(input int which, input int nvalid, input int nexp, input bit custom);
    logic [319:0]  t;
    logic [DW-1:0] r;
    logic [6:0]    key;
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 10; j++) t[j*32 +: 32] = $urandom;
      key = (i >= nvalid) ? 7'h7F : (custom ? ktab[i] : 7'(2 * i + 1));
      r = t[DW-1:0];
      r[KW-1:0] = key;
      if (which == 0) begin
        mem0[i] = r;
        if (i < nexp) q0.push_back(r);
      end else begin
        mem1[i] = r;
        if (i < nexp) q1.push_back(r);
      end
    end
  endtask

  task automatic go0(input logic [6:0] n);
    fl0 = 0; pp0 = 0; in0 = 0; dn0 = 0;
    n0 = n; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic go1(input logic [6:0] n);
    fl1 = 0; pp1 = 0; in1 = 0; dn1 = 0;
    n1 = n; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    int k = 0;
    while (((which == 0) ? dn0 : dn1) == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk((which == 0) ? "dut0_done_timeout" : "dut1_done_timeout",
        ((which == 0) ? dn0 : dn1) != 0, 1);
  endtask

  task automatic finish0(input string tag, input int efl, input int eoc);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_flushes"}, fl0, efl);
    chk({tag, "_out_count"}, oc0, eoc);
    chk({tag, "_records"}, pp0, eoc);
    chk({tag, "_done_pulses"}, dn0, 1);
    chk({tag, "_init_pulses"}, in0, 1);
    chk({tag, "_busy_after"}, busy0, 0);
    chk({tag, "_left_in_sb"}, 32'(q0.size()), 0);
  endtask

  initial begin
    start0 = 1'b0; n0 = '0; mr0 = 1'b1; sdly0 = 3;
    start1 = 1'b0; n1 = '0; mr1 = 1'b1;
    fl0 = 0; pp0 = 0; in0 = 0; dn0 = 0;
    fl1 = 0; pp1 = 0; in1 = 0; dn1 = 0;
    for (int i = 0; i < 64; i++) begin mem0[i] = '1; mem1[i] = '1; ktab[i] = 7'd0; end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init", init0, 0);
    chk("rst_flush", flush0, 0);
    chk("rst_valid", mv0, 0);
    chk("rst_data", md0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_out_count", oc0, 0);
    chk("rst_busy_lat2", busy1, 0);
    chk("rst_valid_lat2", mv1, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: five sorted keys, downstream always ready.
    ktab[0] = 7'd3; ktab[1] = 7'd7; ktab[2] = 7'd9; ktab[3] = 7'd20; ktab[4] = 7'd40;
    load_heap(0, 5, 5, 1'b1);
    go0(7'd5);
    wait_done(0, 200);
    finish0("t1", 5, 5);

    // 2: back-pressure mid-stream; credit must cap outstanding records at the FIFO depth.
    load_heap(0, 12, 12, 1'b0);
    go0(7'd12);
    begin
      int k = 0;
      while (pp0 < 2 && k < 100) begin @(posedge clk); k++; end
    end
    #1;
    mr0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start0 = 1'b1;   // must be ignored while busy
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t2_outstanding_at_stall", fl0 - pp0, 4);
    chk("t2_valid_at_stall", mv0, 1);
    chk("t2_no_flush_at_stall", flush0, 0);
    mr0 = 1'b1;
    wait_done(0, 200);
    finish0("t2", 12, 12);

    // 3: only four valid keys; the fifth read is the empty-slot sentinel.
    sdly0 = 0;
    load_heap(0, 4, 4, 1'b0);
    go0(7'd10);
    wait_done(0, 200);
    finish0("t3", 5, 4);
    sdly0 = 3;

    // 4: request above capacity clamps to 62.
    load_heap(0, 64, 62, 1'b0);
    go0(7'd100);
    wait_done(0, 400);
    finish0("t4", 62, 62);

    // 5: FLUSH_LAT = 2 instance.
    load_heap(1, 6, 6, 1'b0);
    go1(7'd6);
    wait_done(1, 200);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_flushes", fl1, 6);
    chk("t5_out_count", oc1, 6);
    chk("t5_done_pulses", dn1, 1);
    chk("t5_left_in_sb", 32'(q1.size()), 0);

    // 6: reset mid-DRAIN, then an empty session.
    load_heap(0, 20, 20, 1'b0);
    go0(7'd20);
    begin
      int k = 0;
      while (pp0 < 3 && k < 100) begin @(posedge clk); k++; end
    end
    #1;
    mr0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_busy_before_reset", busy0, 1);
    chk("t6_out_count_before_reset", oc0 >= 7'd3, 1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_init", init0, 0);
    chk("t6_rst_flush", flush0, 0);
    chk("t6_rst_valid", mv0, 0);
    chk("t6_rst_data", md0, 0);
    chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_done", done0, 0);
    chk("t6_rst_out_count", oc0, 0);
    q0.delete();
    mr0 = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    go0(7'd0);
    wait_done(0, 50);
    finish0("t6", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

endmodule
